// File: rtl/register_sequencer.sv
// ---------------------------------------------------------------------------
// register_sequencer
//
// Command front-end for the 16 x 8-bit register unit. Accepts one command at
// a time (WRITE, READ, COPY, INC) over a valid/ready handshake, drives the
// register unit's load/addr/data_in pins, captures its registered data_out
// one clock after the address is presented, and returns READ/INC results on
// a valid/ready response port.
//
// Ports:
//   clock      system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   cmd_valid  command present
//   cmd_ready  command accepted this cycle when high with cmd_valid (IDLE only)
//   cmd_op     00 WRITE, 01 READ, 10 COPY, 11 INC
//   cmd_addr   target register (WRITE/READ/INC) or COPY source
//   cmd_addr2  COPY destination
//   cmd_data   WRITE data
//   rsp_valid  response data valid
//   rsp_ready  consumer accepts response
//   rsp_data   READ value or INC result; holds its last value otherwise
//   rf_load    register unit load strobe
//   rf_addr    register unit address
//   rf_wdata   register unit write data
//   rf_rdata   register unit read data, reflects rf_addr of the previous cycle
// ---------------------------------------------------------------------------
module register_sequencer #(
    parameter int register_size = 8,
    parameter int addr_size     = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [addr_size-1:0]     cmd_addr,
    input  logic [addr_size-1:0]     cmd_addr2,
    input  logic [register_size-1:0] cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [register_size-1:0] rsp_data,
    output logic                     rf_load,
    output logic [addr_size-1:0]     rf_addr,
    output logic [register_size-1:0] rf_wdata,
    input  logic [register_size-1:0] rf_rdata
);

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_COPY  = 2'b10,
        OP_INC   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RSP
    } state_e;

    state_e                   state;
    state_e                   state_next;
    op_e                      op;
    logic [addr_size-1:0]     addr;
    logic [addr_size-1:0]     addr2;
    logic [register_size-1:0] data;
    logic [register_size-1:0] tmp;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment up front keeps this block purely
    // combinational; a missing branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_next = (op_e'(cmd_op) == OP_WRITE) ? S_WR : S_RD;
                end
            end
            S_RD:  state_next = S_CAP;
            S_CAP: state_next = (op == OP_READ) ? S_RSP : S_WR;
            S_WR:  state_next = (op == OP_INC) ? S_RSP : S_IDLE;
            S_RSP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: purely from state and the latched command fields.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rf_load   = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        unique case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_RD:   rf_addr   = addr;
            S_CAP:  rf_addr   = addr;
            S_WR: begin
                rf_load  = 1'b1;
                rf_addr  = (op == OP_COPY) ? addr2 : addr;
                rf_wdata = (op == OP_WRITE) ? data : tmp;
            end
            S_RSP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Command latches, captured read data and response register. Reset
    // clears everything so an abandoned COPY/INC leaves no stale data.
    always_ff @(posedge clock) begin
        if (reset) begin
            op       <= OP_WRITE;
            addr     <= '0;
            addr2    <= '0;
            data     <= '0;
            tmp      <= '0;
            rsp_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op    <= op_e'(cmd_op);
                        addr  <= cmd_addr;
                        addr2 <= cmd_addr2;
                        data  <= cmd_data;
                    end
                end
                S_CAP: begin
                    unique case (op)
                        OP_READ: rsp_data <= rf_rdata;
                        OP_COPY: tmp      <= rf_rdata;
                        // Wraps modulo 2**register_size.
                        OP_INC:  tmp      <= register_size'(rf_rdata + 1'b1);
                        default: ;
                    endcase
                end
                S_WR: begin
                    if (op == OP_INC) begin
                        rsp_data <= tmp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_sequencer.sv
// ---------------------------------------------------------------------------
// tb_register_sequencer
//
// Directed bench for register_sequencer. A behavioural 16 x 8 register unit
// (registered data_out) sits downstream. Expected responses and expected
// register writes are pushed into queues as commands are issued; monitors on
// the falling edge pop and compare whenever the DUT presents a response
// handshake or a write strobe.
// ---------------------------------------------------------------------------
module tb_register_sequencer;

    localparam int RS = 8;
    localparam int AS = 4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_INC   = 2'b11;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AS-1:0] cmd_addr;
    logic [AS-1:0] cmd_addr2;
    logic [RS-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RS-1:0] rsp_data;
    logic          rf_load;
    logic [AS-1:0] rf_addr;
    logic [RS-1:0] rf_wdata;
    logic [RS-1:0] rf_rdata;

    int checks = 0;
    int errors = 0;

    logic [RS-1:0]    rsp_q[$];
    logic [AS+RS-1:0] wr_q[$];

    logic [RS-1:0] mem [2**AS];

    register_sequencer #(.register_size(RS), .addr_size(AS)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_addr2 (cmd_addr2),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rf_load   (rf_load),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    always #5 clock = ~clock;

    // Register unit: write on load, data_out registered from addr.
    initial begin
        for (int i = 0; i < 2**AS; i++) mem[i] = '0;
        rf_rdata = '0;
    end

    always @(posedge clock) begin
        if (rf_load) mem[rf_addr] <= rf_wdata;
        rf_rdata <= mem[rf_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor.
    always @(negedge clock) begin
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                check("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
            end
        end
    end

    // Write monitor.
    always @(negedge clock) begin
        if (rf_load) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'(rf_load), 32'd0);
            end else begin
                check("write_addr_data", 32'({rf_addr, rf_wdata}), 32'(wr_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents a command and returns in the cycle after the acceptance edge.
    task automatic send(input logic [1:0] op, input logic [AS-1:0] a,
                        input logic [AS-1:0] a2, input logic [RS-1:0] d);
        logic accepted;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_addr2 = a2;
        cmd_data  = d;
        for (int i = 0; i < 50 && !accepted; i++) begin
            accepted = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        if (!accepted) check("send_timeout", 32'(accepted), 32'd1);
    endtask

    // Counts cycles until cmd_ready returns.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (!cmd_ready && cycles < 100) begin
            tick();
            cycles++;
        end
        if (!cmd_ready) check("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        logic [6:0] pat;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_addr2 = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rf_load",   32'(rf_load),   32'd0);
        check("reset_rf_addr",   32'(rf_addr),   32'd0);
        check("reset_rf_wdata",  32'(rf_wdata),  32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'd0);
        reset = 1'b0;

        // 1: WRITE 3 <- 0x5A, then READ 3.
        wr_q.push_back({4'd3, 8'h5A});
        send(OP_WRITE, 4'd3, 4'd0, 8'h5A);
        check("t1_wr_load",  32'(rf_load),  32'd1);
        check("t1_wr_addr",  32'(rf_addr),  32'd3);
        check("t1_wr_wdata", 32'(rf_wdata), 32'h5A);
        tick();
        check("t1_wr_load_one_cycle", 32'(rf_load),   32'd0);
        check("t1_ready_T2",          32'(cmd_ready), 32'd1);
        rsp_q.push_back(8'h5A);
        send(OP_READ, 4'd3, 4'd0, 8'h00);
        check("t1_rd_addr",   32'(rf_addr),   32'd3);
        check("t1_no_rsp_T1", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_no_rsp_T2", 32'(rsp_valid), 32'd0);
        tick();
        check("t1_rsp_T3",    32'(rsp_valid), 32'd1);
        wait_idle(n);

        // 2: WRITE 7 <- 0xFF, INC 7 wraps to 0x00, READ 7.
        wr_q.push_back({4'd7, 8'hFF});
        send(OP_WRITE, 4'd7, 4'd0, 8'hFF);
        wait_idle(n);
        wr_q.push_back({4'd7, 8'h00});
        rsp_q.push_back(8'h00);
        send(OP_INC, 4'd7, 4'd0, 8'h00);
        wait_idle(n);
        check("t2_inc_latency", 32'(n), 32'd4);
        rsp_q.push_back(8'h00);
        send(OP_READ, 4'd7, 4'd0, 8'h00);
        wait_idle(n);
        check("t2_read_latency", 32'(n), 32'd3);

        // 3: WRITE 1 <- 0x3C, COPY 1 -> 14, READ 14, READ 1.
        wr_q.push_back({4'd1, 8'h3C});
        send(OP_WRITE, 4'd1, 4'd0, 8'h3C);
        wait_idle(n);
        check("t3_write_latency", 32'(n), 32'd1);
        wr_q.push_back({4'd14, 8'h3C});
        send(OP_COPY, 4'd1, 4'd14, 8'h00);
        wait_idle(n);
        check("t3_copy_latency", 32'(n), 32'd3);
        rsp_q.push_back(8'h3C);
        send(OP_READ, 4'd14, 4'd0, 8'h00);
        wait_idle(n);
        rsp_q.push_back(8'h3C);
        send(OP_READ, 4'd1, 4'd0, 8'h00);
        wait_idle(n);

        // 4: READ 2 with a 10-cycle response stall and an ignored command.
        wr_q.push_back({4'd2, 8'hA7});
        send(OP_WRITE, 4'd2, 4'd0, 8'hA7);
        wait_idle(n);
        rsp_ready = 1'b0;
        rsp_q.push_back(8'hA7);
        send(OP_READ, 4'd2, 4'd0, 8'h00);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t4_stall_valid", 32'(rsp_valid), 32'd1);
            check("t4_stall_data",  32'(rsp_data),  32'hA7);
            check("t4_stall_ready", 32'(cmd_ready), 32'd0);
            if (i == 3) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_WRITE;
                cmd_addr  = 4'd2;
                cmd_data  = 8'h00;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t4_idle_after_hs", 32'(cmd_ready), 32'd1);
        check("t4_valid_dropped", 32'(rsp_valid), 32'd0);
        check("t4_data_retained", 32'(rsp_data),  32'hA7);
        rsp_q.push_back(8'hA7);
        send(OP_READ, 4'd2, 4'd0, 8'h00);
        wait_idle(n);

        // 5: reset during the CAP cycle of INC 5.
        wr_q.push_back({4'd5, 8'h10});
        send(OP_WRITE, 4'd5, 4'd0, 8'h10);
        wait_idle(n);
        send(OP_INC, 4'd5, 4'd0, 8'h00);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_ready_after_rst", 32'(cmd_ready), 32'd1);
        check("t5_valid_after_rst", 32'(rsp_valid), 32'd0);
        check("t5_load_after_rst",  32'(rf_load),   32'd0);
        for (int i = 0; i < 4; i++) tick();
        rsp_q.push_back(8'h10);
        send(OP_READ, 4'd5, 4'd0, 8'h00);
        wait_idle(n);

        // 6: back-to-back WRITE 0 <- 0x11 then READ 0 with cmd_valid held.
        pat = 7'b1000101;
        wr_q.push_back({4'd0, 8'h11});
        rsp_q.push_back(8'h11);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 4'd0;
        cmd_data  = 8'h11;
        for (int i = 0; i < 7; i++) begin
            check("t6_ready_pattern", 32'(cmd_ready), 32'(pat[i]));
            if (i == 6) cmd_valid = 1'b0;
            tick();
            if (i == 0) begin
                cmd_op   = OP_READ;
                cmd_data = 8'h00;
            end
        end
        tick();

        check("rsp_queue_drained",   32'(rsp_q.size()), 32'd0);
        check("write_queue_drained", 32'(wr_q.size()),  32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
